wired_rob_ptr: RTL
==================

WIRED_ROB_PTR -- requirements
Module: wired_rob_ptr

Interface
REQ-001 SHALL have parameter ROB_LEN, default 6, giving log2 of ROB depth (ROB ids are ROB_LEN bits wide).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port alloc_req_i  input  2  dispatch slot requests; legal values 00, 01, 11.
REQ-005 SHALL have port alloc_ready_o  output  1  all requested slots granted this cycle.
REQ-006 SHALL have port alloc_rid_o  output  2xROB_LEN  ids for slot0/slot1, i.e. tail and tail+1.
REQ-007 SHALL have port commit_rid_o  output  2xROB_LEN  head and head+1; drives the ROB commit read ids.
REQ-008 SHALL have port commit_valid_i  input  2  ROB entry at head / head+1 is complete.
REQ-009 SHALL have port retire_i  input  2  commit stage retires head / head+1.
REQ-010 SHALL have port retire_o  output  2  accepted retires; drives the ROB retire input.
REQ-011 SHALL have port redirect_i  input  1  backend cancel request.
REQ-012 SHALL have port walk_o  output  2  walk-retire valid toward rename, slots head / head+1.
REQ-013 SHALL have port rob_flush_o  output  1  one-cycle ROB clear pulse.
REQ-014 SHALL have ports count_o (ROB_LEN+1), empty_o (1), full_o (1), all outputs giving occupancy.

Function
REQ-015 SHALL hold head and tail as ROB_LEN+1-bit pointers; the MSB is the wrap bit; ids are the low ROB_LEN bits, modulo 2^ROB_LEN.
REQ-016 SHALL compute count = tail - head (ROB_LEN+1 bits); empty_o = (count==0); full_o = (count==2^ROB_LEN).
REQ-017 SHALL drive alloc_ready_o = (state==RUN) & ~redirect_i & (2^ROB_LEN - count >= popcount(alloc_req_i)), combinationally.
REQ-018 SHALL advance tail by popcount(alloc_req_i) when alloc_ready_o=1; otherwise tail holds and no slot is granted (all-or-nothing).
REQ-019 SHALL compute retire_o[0] = RUN & retire_i[0] & commit_valid_i[0] & (count>=1), and retire_o[1] = retire_o[0] & retire_i[1] & commit_valid_i[1] & (count>=2).
REQ-020 SHALL advance head by popcount(retire_o); any non-prefix or unqualified retire_i bit SHALL be dropped.
REQ-021 SHALL apply alloc and retire in the same cycle together: next count = count + allocs - retires. Alloc availability uses the pre-retire count.
REQ-022 SHALL implement FSM states RUN, WALK, CLEAR; reset state RUN.
REQ-023 RUN->WALK SHALL occur when redirect_i=1. Retires in that cycle SHALL still apply; allocs SHALL be blocked.
REQ-024 In WALK: walk_o[0] = (count>=1) and walk_o[1] = (count>=2). Head SHALL advance by popcount(walk_o). Retire_o and alloc SHALL be 0.
REQ-025 WALK->CLEAR SHALL occur in the cycle where count<=2, including count==0 on entry.
REQ-026 In CLEAR: rob_flush_o=1 for exactly one cycle; head and tail SHALL be set to 0; next state RUN.
REQ-027 SHALL ignore redirect_i in WALK and CLEAR.
REQ-028 SHALL have walk_o=0 and rob_flush_o=0 outside WALK and CLEAR respectively.
REQ-029 SHALL have commit_rid_o and alloc_rid_o valid in every state; they are purely functions of head and tail.

Reset
REQ-030 When rst_n=0 at a clock edge, the block SHALL set head=tail=0 and state=RUN, overriding all other inputs.
REQ-031 After reset the block SHALL present count_o=0, empty_o=1, full_o=0, walk_o=0, rob_flush_o=0, retire_o=0, alloc_ready_o=1 (absent redirect), alloc_rid_o={1,0} and commit_rid_o={1,0}.
REQ-032 Reset asserted mid-WALK or mid-CLEAR SHALL abort without a rob_flush_o pulse.

Verification (ROB_LEN=6)
REQ-033 Reset, then alloc_req=11 for 32 cycles -> alloc_rid pairs (0,1)..(62,63); then full_o=1, count_o=64, alloc_ready_o=0 for alloc_req=01.
REQ-034 Pointers at head=tail=62, alloc 11 for one cycle -> alloc_rid_o=(62,63); then alloc 11 again -> alloc_rid_o=(0,1) wrapping, count_o=4.
REQ-035 count=63, alloc 01 with retire_i=11 and commit_valid_i=11 -> retire_o=11, count_o=62 next cycle; with retire_i=10 instead -> retire_o=00, count_o=64.
REQ-036 count=5, head=10, redirect_i=1 -> walk_o=11 with rids (10,11), then 11 with rids (12,13), then 01 with rid 14; then rob_flush_o pulse; then RUN with count_o=0 and alloc_rid_o=(0,1).
REQ-037 count=0, redirect_i=1 -> WALK with walk_o=00, then CLEAR with rob_flush_o=1, then RUN; total 3 cycles with alloc_ready_o=0.
REQ-038 rst_n=0 during WALK at count=3 -> next cycle RUN, count_o=0, no rob_flush_o pulse.

Source files
------------

// File: rtl/wired_rob_ptr.sv
// rtl/wired_rob_ptr.sv - ROB head/tail pointer control with allocate, retire, redirect walk and clear
module wired_rob_ptr #(
    parameter int ROB_LEN = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             alloc_req_i,
    output logic                   alloc_ready_o,
    output logic [2*ROB_LEN-1:0]   alloc_rid_o,
    output logic [2*ROB_LEN-1:0]   commit_rid_o,
    input  logic [1:0]             commit_valid_i,
    input  logic [1:0]             retire_i,
    output logic [1:0]             retire_o,
    input  logic                   redirect_i,
    output logic [1:0]             walk_o,
    output logic                   rob_flush_o,
    output logic [ROB_LEN:0]       count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PW = ROB_LEN + 1;
    localparam logic [PW-1:0]      C_DEPTH = {1'b1, {ROB_LEN{1'b0}}};
    localparam logic [PW-1:0]      C_ONE   = PW'(1);
    localparam logic [PW-1:0]      C_TWO   = PW'(2);
    localparam logic [ROB_LEN-1:0] C_ID1   = ROB_LEN'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WALK  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [PW-1:0]       w_head_nxt;
    logic [PW-1:0]       w_tail_nxt;

    logic [PW-1:0]       w_count;
    logic [PW-1:0]       w_free;
    logic [PW-1:0]       w_alloc_num;
    logic [PW-1:0]       w_head_step;
    logic                w_ge1;
    logic                w_ge2;
    logic [ROB_LEN-1:0]  w_head_id;
    logic [ROB_LEN-1:0]  w_tail_id;

    // Occupancy and slot ids derived from the wrap-bit pointers
    always_comb begin
        w_count     = r_tail - r_head;
        w_free      = C_DEPTH - w_count;
        w_alloc_num = PW'(alloc_req_i[0]) + PW'(alloc_req_i[1]);
        w_ge1       = (w_count >= C_ONE);
        w_ge2       = (w_count >= C_TWO);
        w_head_id   = r_head[ROB_LEN-1:0];
        w_tail_id   = r_tail[ROB_LEN-1:0];
    end

    // Pointer-only outputs, valid in every state
    always_comb begin
        count_o      = w_count;
        empty_o      = (w_count == '0);
        full_o       = (w_count == C_DEPTH);
        alloc_rid_o  = {w_tail_id + C_ID1, w_tail_id};
        commit_rid_o = {w_head_id + C_ID1, w_head_id};
    end

    // Next-state, pointer updates and handshake outputs; alloc sees the pre-retire count
    always_comb begin
        w_state_nxt   = r_state;
        w_head_nxt    = r_head;
        w_tail_nxt    = r_tail;
        w_head_step   = '0;
        alloc_ready_o = 1'b0;
        retire_o      = 2'b00;
        walk_o        = 2'b00;
        rob_flush_o   = 1'b0;

        case (r_state)
            ST_RUN: begin
                alloc_ready_o = ~redirect_i & (w_free >= w_alloc_num);
                retire_o[0]   = retire_i[0] & commit_valid_i[0] & w_ge1;
                retire_o[1]   = retire_o[0] & retire_i[1] & commit_valid_i[1] & w_ge2;
                w_head_step   = PW'(retire_o[0]) + PW'(retire_o[1]);
                w_head_nxt    = r_head + w_head_step;
                if (alloc_ready_o) begin
                    w_tail_nxt = r_tail + w_alloc_num;
                end
                // Retires in the redirect cycle still land; only allocation is held off
                if (redirect_i) begin
                    w_state_nxt = ST_WALK;
                end
            end
            ST_WALK: begin
                walk_o      = {w_ge2, w_ge1};
                w_head_step = PW'(walk_o[0]) + PW'(walk_o[1]);
                w_head_nxt  = r_head + w_head_step;
                // The final walk group (0, 1 or 2 entries) empties the ROB
                if (!w_ge2 || (w_count == C_TWO)) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                rob_flush_o = 1'b1;
                w_head_nxt  = '0;
                w_tail_nxt  = '0;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_head_nxt  = '0;
                w_tail_nxt  = '0;
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State and pointer registers; reset overrides every other input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

endmodule
